// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver: per-frame snapshot of digit codes,
// per-digit blink, anode guard interval; active-low registered an/seg.
module seg7_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic [3:0] dig2,
  input  logic [3:0] dig3,
  input  logic [3:0] blink_mask,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0] CODE_BLANK = 4'd10;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;

  logic [DW-1:0]   div_cnt;
  logic [1:0]      pos;
  logic [FW-1:0]   frame_cnt;
  logic            phase;
  logic [3:0][3:0] sh_dig;
  logic [3:0]      sh_mask;

  logic       tick;
  logic       snap;
  logic       frame_wrap;
  logic       guard_on;
  logic [3:0] cur_code;
  logic       cur_blank;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd11:   s = 7'b0111111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Inputs carry no handshake: dig0..dig3 and blink_mask are sampled only on
  // the last cycle of slot 3, and that sample drives the whole next frame.
  always_comb begin
    tick       = (div_cnt == DW'(SCAN_DIV - 1));
    snap       = tick && (pos == 2'd3);
    frame_wrap = (frame_cnt == FW'(BLINK_FRAMES - 1));
    guard_on   = (GUARD > 0) && (div_cnt < DW'(GUARD));
    cur_code   = sh_dig[pos];
    cur_blank  = phase & sh_mask[pos];
    an_next    = guard_on ? 4'b1111 : ~(4'b0001 << pos);
    seg_next   = cur_blank ? SEG_BLANK : decode(cur_code);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      pos       <= 2'd0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      sh_dig    <= {4{CODE_BLANK}};
      sh_mask   <= 4'b0000;
      an        <= 4'b1111;
      seg       <= SEG_BLANK;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) pos <= pos + 2'd1;
      // Phase flips on the same edge that loads the frame it applies to.
      if (snap) begin
        sh_dig    <= {dig3, dig2, dig1, dig0};
        sh_mask   <= blink_mask;
        frame_cnt <= frame_wrap ? '0 : frame_cnt + FW'(1);
        if (frame_wrap) phase <= ~phase;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-indexed reference model pushes the
// expected {an,seg} each edge; a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  localparam int SD    = 8;
  localparam int GD    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] dig0 = 4'd0, dig1 = 4'd0, dig2 = 4'd0, dig3 = 4'd0;
  logic [3:0] blink_mask = 4'b0000;
  logic [3:0] an;
  logic [6:0] seg;

  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: cycles since reset release, and the frame's captured data
  int              c        = 0;
  bit              model_on = 1'b0;
  logic [3:0][3:0] m_dig    = {4{4'd10}};
  logic [3:0]      m_mask   = 4'b0000;

  seg7_scan_driver #(.SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .blink_mask(blink_mask), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] code);
    case (code)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      4'd11: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  // frame f has seen f snapshots; phase flips every BF of them
  function automatic bit phase_of(input int cyc);
    return ((cyc / FRAME) / BF) % 2 == 1;
  endfunction

  function automatic int pos_of(input int cyc);
    return (cyc / SD) % 4;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      c        = 0;
      m_dig    = {4{4'd10}};
      m_mask   = 4'b0000;
      exp_q.push_back({4'b1111, 7'b1111111});
    end else if (model_on) begin
      int         p;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      p     = pos_of(c);
      e_an  = ((c % SD) < GD) ? 4'b1111 : ~(4'b0001 << p);
      e_seg = (phase_of(c) && m_mask[p]) ? 7'b1111111 : seg_of(m_dig[p]);
      exp_q.push_back({e_an, e_seg});
      if ((c % FRAME) == FRAME - 1) begin
        m_dig  = {dig3, dig2, dig1, dig0};
        m_mask = blink_mask;
      end
      c = c + 1;
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if ({an, seg} !== e) begin
        n_fail++;
        $display("FAIL display_out cyc=%0d got an=%b seg=%b expected an=%b seg=%b",
                 c, an, seg, e[10:7], e[6:0]);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_digits(input logic [3:0] d0, d1, d2, d3, input logic [3:0] m);
    dig0 = d0; dig1 = d1; dig2 = d2; dig3 = d3; blink_mask = m;
  endtask

  // wait until the DUT is in slot p (and optionally blink phase 1), bounded
  task automatic wait_slot(input int p, input bit need_phase, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 50 * FRAME && !found; i++) begin
      @(negedge clk);
      if (pos_of(c) == p && (!need_phase || phase_of(c))) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_%s got timeout expected slot %0d", tag, p);
    end
  endtask

  initial begin
    set_digits(4'd5, 4'd2, 4'd11, 4'd3, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(3 * FRAME);

    // tear-free: change dig0 mid-frame
    wait_slot(2, 1'b0, "tear");
    dig0 = 4'd7;
    cycles(2 * FRAME);

    set_digits(4'd12, 4'd13, 4'd14, 4'd15, 4'b0000);
    cycles(2 * FRAME);

    set_digits(4'd5, 4'd2, 4'd11, 4'd3, 4'b0001);
    cycles(8 * FRAME);

    // mid-frame reset during the blank blink phase
    wait_slot(2, 1'b1, "reset");
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(3 * FRAME);

    for (int k = 0; k < 40; k++) begin
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
      end
      cycles($urandom_range(1, 2 * FRAME));
    end
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
